// File: rtl/ifetch32_pkg.sv
// Shared definitions for the instruction fetch stage.
package ifetch32_pkg;

    // Default reset PC for the fetch stage.
    localparam logic [31:0] RESET_PC_VAL = 32'h0000_0000;

    // Next-PC source, listed from lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } pc_sel_e;

    // j/jal target: upper nibble of pc+4, 26-bit index, word aligned.
    function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                                input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch32_next_pc_sel.sv
// Next-PC priority mux with misaligned-target detection (combinational).
module ifetch32_next_pc_sel
    import ifetch32_pkg::*;
(
    input  logic [31:0] seq_pc,
    input  logic [3:0]  jump_hi,
    input  logic [25:0] instr_index,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jr,
    input  logic        zero,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    pc_sel_e     sel;
    logic        taken;
    logic [31:0] target;

    // Resolve the source by fixed priority, then force word alignment.
    always_comb begin
        taken = (branch & zero) | (nbranch & ~zero);
        sel   = SEL_SEQ;
        if (jr)
            sel = SEL_JR;
        else if (jmp | jal)
            sel = SEL_JUMP;
        else if (taken)
            sel = SEL_BRANCH;

        case (sel)
            SEL_JR:     target = jr_target;
            SEL_JUMP:   target = jump_target(jump_hi, instr_index);
            SEL_BRANCH: target = branch_target;
            default:    target = seq_pc;
        endcase

        misaligned = |target[1:0];
        next_pc    = {target[31:2], 2'b00};
    end

endmodule

// File: rtl/ifetch32.sv
// Instruction fetch stage: PC register, ROM addressing, retired-instruction
// counter and sticky misaligned-target flag.
module ifetch32
    import ifetch32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VAL,
    parameter int unsigned ROM_AW   = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       Instruction,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              Zero,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    output logic [31:0]       pc_out,
    output logic [31:0]       opcplus4,
    output logic              fetch_err,
    output logic [31:0]       instr_count
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        misaligned;

    assign opcplus4    = pc + 32'd4;
    assign pc_out      = pc;
    assign rom_addr    = pc[ROM_AW+1:2];
    assign Instruction = rom_data;

    ifetch32_next_pc_sel u_next_pc_sel (
        .seq_pc        (opcplus4),
        .jump_hi       (opcplus4[31:28]),
        .instr_index   (rom_data[25:0]),
        .branch_target (Addr_result),
        .jr_target     (Read_data_1),
        .branch        (Branch),
        .nbranch       (nBranch),
        .jmp           (Jmp),
        .jal           (Jal),
        .jr            (Jr),
        .zero          (Zero),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    // PC, retired count and sticky error flag; reset overrides stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            fetch_err   <= 1'b0;
            instr_count <= '0;
        end else if (!stall) begin
            pc          <= next_pc;
            instr_count <= instr_count + 32'd1;
            if (misaligned)
                fetch_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifetch32.sv
// Directed self-checking bench for ifetch32.
module tb_ifetch32;

    logic        clock = 1'b0;
    logic        reset, stall;
    logic [13:0] rom_addr;
    logic [31:0] rom_data, Instruction;
    logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Addr_result, Read_data_1;
    logic [31:0] pc_out, opcplus4, instr_count;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_count;

    ifetch32 #(.RESET_PC(32'h0000_0000), .ROM_AW(14)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .Instruction (Instruction),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_result (Addr_result),
        .Read_data_1 (Read_data_1),
        .pc_out      (pc_out),
        .opcplus4    (opcplus4),
        .fetch_err   (fetch_err),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_ctl();
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
        Addr_result = '0; Read_data_1 = '0; rom_data = '0;
    endtask

    // One rising edge, then settle away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Non-stalled edge that loads pc via jr.
    task automatic jump_to(input logic [31:0] target);
        clear_ctl();
        Jr = 1; Read_data_1 = target;
        step();
        exp_count = exp_count + 1;
        clear_ctl();
    endtask

    initial begin
        reset = 1; stall = 0;
        clear_ctl();
        step();
        step();
        check("reset_pc", pc_out, 32'h0);
        check("reset_count", instr_count, 32'h0);
        check("reset_err", {31'b0, fetch_err}, 32'h0);
        check("reset_opcplus4", opcplus4, 32'h4);
        check("reset_rom_addr", {18'b0, rom_addr}, 32'h0);

        reset = 0;
        exp_count = 0;
        step(); check("seq_pc1", pc_out, 32'h4);
        step(); check("seq_pc2", pc_out, 32'h8);
        step(); check("seq_pc3", pc_out, 32'hC);
        exp_count = 3;
        check("seq_count", instr_count, 32'd3);
        check("seq_err", {31'b0, fetch_err}, 32'h0);
        check("seq_rom_addr", {18'b0, rom_addr}, 32'h3);

        // beq taken
        jump_to(32'h10);
        check("jr_to_10", pc_out, 32'h10);
        Branch = 1; Zero = 1; Addr_result = 32'h40;
        step(); exp_count++;
        check("beq_taken", pc_out, 32'h40);
        // beq not taken
        jump_to(32'h10);
        Branch = 1; Zero = 0; Addr_result = 32'h40;
        step(); exp_count++;
        check("beq_not_taken", pc_out, 32'h14);
        // bne taken
        jump_to(32'h10);
        nBranch = 1; Zero = 0; Addr_result = 32'h40;
        step(); exp_count++;
        check("bne_taken", pc_out, 32'h40);
        // bne not taken
        jump_to(32'h10);
        nBranch = 1; Zero = 1; Addr_result = 32'h40;
        step(); exp_count++;
        check("bne_not_taken", pc_out, 32'h14);

        // jal
        jump_to(32'h1000_0008);
        rom_data = 32'h0C00_0100;
        Jal = 1;
        #1;
        check("jal_opcplus4", opcplus4, 32'h1000_000C);
        check("jal_instruction", Instruction, 32'h0C00_0100);
        step(); exp_count++;
        check("jal_target", pc_out, 32'h1000_0400);
        clear_ctl();

        // j with upper nibble carried from pc+4
        jump_to(32'h2000_0000);
        rom_data = 32'h0800_0010; Jmp = 1;
        step(); exp_count++;
        check("j_target", pc_out, 32'h2000_0040);
        clear_ctl();
        check("count_mid", instr_count, exp_count);
        check("err_before_misalign", {31'b0, fetch_err}, 32'h0);

        // jr beats jmp and taken branch; misaligned target
        Jr = 1; Jmp = 1; Read_data_1 = 32'h0000_0203;
        Branch = 1; Zero = 1; Addr_result = 32'h40;
        step(); exp_count++;
        check("jr_priority_pc", pc_out, 32'h200);
        check("misalign_err", {31'b0, fetch_err}, 32'h1);
        clear_ctl();
        for (int i = 0; i < 5; i++) begin
            step(); exp_count++;
            check("err_sticky", {31'b0, fetch_err}, 32'h1);
        end
        check("after_err_pc", pc_out, 32'h214);

        // misaligned branch target
        Branch = 1; Zero = 1; Addr_result = 32'h0000_0302;
        step(); exp_count++;
        check("misalign_branch_pc", pc_out, 32'h300);
        clear_ctl();

        // stall holds through a taken branch
        stall = 1; Branch = 1; Zero = 1; Addr_result = 32'h80;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_pc", pc_out, 32'h300);
            check("stall_count", instr_count, exp_count);
        end
        stall = 0; Branch = 0;
        step(); exp_count++;
        check("stall_release_pc", pc_out, 32'h304);
        check("stall_release_count", instr_count, exp_count);
        clear_ctl();

        // pc wrap and rom aliasing
        jump_to(32'hFFFF_FFFC);
        check("wrap_opcplus4", opcplus4, 32'h0);
        check("top_rom_addr", {18'b0, rom_addr}, 32'h3FFF);
        step(); exp_count++;
        check("wrap_pc", pc_out, 32'h0);
        jump_to(32'h0001_0000);
        check("alias_rom_addr", {18'b0, rom_addr}, 32'h0);
        jump_to(32'h0000_FFFC);
        check("max_rom_addr", {18'b0, rom_addr}, 32'h3FFF);
        check("count_final", instr_count, exp_count);
        check("err_still_set", {31'b0, fetch_err}, 32'h1);

        // reset overrides stall and clears the flag
        Jr = 1; Read_data_1 = 32'h500;
        reset = 1; stall = 1;
        step();
        check("rst_stall_pc", pc_out, 32'h0);
        check("rst_stall_count", instr_count, 32'h0);
        check("rst_stall_err", {31'b0, fetch_err}, 32'h0);
        reset = 0; stall = 0;
        clear_ctl();
        step();
        check("post_rst_pc", pc_out, 32'h4);
        check("post_rst_count", instr_count, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
